j1_io_interconnect: RTL and testbench

//  Parametrised J1 I/O bus controller: decodes j1_io_addr[15:8] against N_SLAVES pages, returns the read mux
//  and adds per-access ack/wait-state handshake with stall, timeout, and error logging. Sits between the J1 CPU
//  and all peripherals; replaces the fixed 5-way combinational chip-select/read mux in the SoC top.

---
 rtl/j1_io_interconnect.sv | 139 +++++++++++++
 tb/tb_j1_io_interconnect.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/j1_io_interconnect.sv
// j1_io_interconnect: J1 I/O bus controller with page decode, read mux, ack/wait-state handshake, timeout and error log
// Ports: sys_clk_i/sys_rst_i clock and async active-high reset; j1_io_* CPU side (rd/wr strobes, addr, write data,
//   read data, stall); per_* peripheral side (one-hot select, strobes, offset, write data, per-slave read data and ack);
//   err_irq sticky error flag cleared by a write to status offset 0.
module j1_io_interconnect #(
   parameter int                    N_SLAVES     = 5,
   parameter logic [N_SLAVES*8-1:0] PAGE_MAP     = {8'h71, 8'h70, 8'h69, 8'h68, 8'h67},
   parameter logic [7:0]            STAT_PAGE    = 8'h7F,
   parameter int                    TIMEOUT      = 15,
   parameter logic [15:0]           DEFAULT_DATA = 16'h0666
) (
   input  logic                     sys_clk_i,
   input  logic                     sys_rst_i,
   input  logic                     j1_io_rd,
   input  logic                     j1_io_wr,
   input  logic [15:0]              j1_io_addr,
   input  logic [15:0]              j1_io_dout,
   output logic [15:0]              j1_io_din,
   output logic                     j1_io_stall,
   output logic [N_SLAVES-1:0]      per_cs,
   output logic                     per_rd,
   output logic                     per_wr,
   output logic [7:0]               per_addr,
   output logic [15:0]              per_din,
   input  logic [N_SLAVES*16-1:0]   per_dout,
   input  logic [N_SLAVES-1:0]      per_ack,
   output logic                     err_irq
);
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
   state_t state, state_n;
   logic [15:0] addr_q, rdata_q, wait_cnt, err_count, last_err_addr, rd_mux;
   logic [2:0] err_cause;
   logic [N_SLAVES-1:0] hit_oh;
   logic req, conflict, hit, stat_hit, unmapped, ack, launch, timeout, log_bad, stat_clr;
   logic [7:0] offset;
   assign req      = j1_io_rd | j1_io_wr;
   assign conflict = j1_io_rd & j1_io_wr;
   assign offset   = j1_io_addr[7:0];
   assign stat_hit = !hit && j1_io_addr[15:8] == STAT_PAGE;
   assign unmapped = !hit && j1_io_addr[15:8] != STAT_PAGE;
   assign ack      = |(per_ack & per_cs);
   // first matching slave wins so duplicate pages resolve to the lowest index
   always_comb begin
      hit = 1'b0;
      hit_oh = '0;
      for (int i = 0; i < N_SLAVES; i++)
         if (!hit && j1_io_addr[15:8] == PAGE_MAP[i*8 +: 8]) begin
            hit = 1'b1;
            hit_oh[i] = 1'b1;
         end
   end
   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < N_SLAVES; i++)
         rd_mux = rd_mux | (per_cs[i] ? per_dout[i*16 +: 16] : 16'h0000);
   end
   always_ff @(posedge sys_clk_i or posedge sys_rst_i)
      if (sys_rst_i) state <= IDLE;
      else state <= state_n;
   always_comb begin
      state_n = state;
      launch = 1'b0;
      timeout = 1'b0;
      log_bad = 1'b0;
      stat_clr = 1'b0;
      j1_io_stall = 1'b0;
      j1_io_din = DEFAULT_DATA;
      case (state)
         IDLE: begin
            log_bad = req && (conflict || unmapped);
            launch = req && !conflict && hit;
            stat_clr = j1_io_wr && !j1_io_rd && stat_hit && offset == 8'd0;
            j1_io_stall = launch;
            state_n = launch ? ACCESS : IDLE;
            if (j1_io_rd && !j1_io_wr && stat_hit)
               j1_io_din = offset == 8'd0 ? err_count :
                           offset == 8'd1 ? last_err_addr :
                           offset == 8'd2 ? {13'b0, err_cause} : DEFAULT_DATA;
         end
         ACCESS: begin
            j1_io_stall = 1'b1;
            // an ack on the last allowed cycle beats the timeout
            timeout = !ack && wait_cnt == TO_LAST;
            state_n = (ack || timeout) ? DONE : ACCESS;
         end
         DONE: begin
            j1_io_din = rdata_q;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      if (sys_rst_i) j1_io_stall = 1'b0;
   end
   always_ff @(posedge sys_clk_i or posedge sys_rst_i)
      if (sys_rst_i) begin
         per_cs <= '0;
         per_rd <= 1'b0;
         per_wr <= 1'b0;
         per_addr <= '0;
         per_din <= '0;
         addr_q <= '0;
         wait_cnt <= '0;
         rdata_q <= DEFAULT_DATA;
         err_count <= '0;
         last_err_addr <= '0;
         err_cause <= '0;
         err_irq <= 1'b0;
      end else begin
         if (launch) begin
            per_cs <= hit_oh;
            per_rd <= j1_io_rd;
            per_wr <= j1_io_wr;
            per_addr <= offset;
            per_din <= j1_io_dout;
            addr_q <= j1_io_addr;
            wait_cnt <= '0;
         end
         if (state == ACCESS) begin
            if (ack || timeout) begin
               per_cs <= '0;
               per_rd <= 1'b0;
               per_wr <= 1'b0;
            end else wait_cnt <= wait_cnt + 16'd1;
            if (ack && per_rd) rdata_q <= rd_mux;
            if (timeout) rdata_q <= DEFAULT_DATA;
         end
         if (log_bad || timeout) begin
            err_count <= err_count == 16'hFFFF ? err_count : err_count + 16'd1;
            last_err_addr <= timeout ? addr_q : j1_io_addr;
            err_cause <= err_cause | {log_bad & conflict, log_bad & unmapped, timeout};
            err_irq <= 1'b1;
         end else if (stat_clr) begin
            err_count <= '0;
            err_cause <= '0;
            err_irq <= 1'b0;
         end
      end
endmodule

// File: tb/tb_j1_io_interconnect.sv
// tb_j1_io_interconnect: randomized self-checking bench for j1_io_interconnect against a transaction-level model
module tb_j1_io_interconnect;
   localparam int N = 5;
   localparam int TIMEOUT = 15;
   localparam logic [15:0] DEF = 16'h0666;
   localparam logic [7:0] STAT = 8'h7F;
   localparam logic [7:0] PAGES [N] = '{8'h67, 8'h68, 8'h69, 8'h70, 8'h71};
   typedef struct packed {
      int stall;
      int wr_cyc;
      logic [15:0] din;
      logic [N-1:0] cs;
      logic [N-1:0] cs_done;
      logic rd;
      logic wr;
      logic [7:0] addr;
      logic [15:0] dat;
   } obs_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic j1_io_rd = 1'b0, j1_io_wr = 1'b0;
   logic [15:0] j1_io_addr = '0, j1_io_dout = '0;
   logic [15:0] j1_io_din;
   logic j1_io_stall;
   logic [N-1:0] per_cs;
   logic per_rd, per_wr;
   logic [7:0] per_addr;
   logic [15:0] per_din;
   logic [N*16-1:0] per_dout = '0;
   logic [N-1:0] per_ack = '0;
   logic err_irq;
   int passed = 0, total = 0;
   logic [15:0] m_cnt, m_last, m_rdata;
   logic [2:0] m_cause;
   logic m_irq;
   always #5 clk = ~clk;
   j1_io_interconnect dut (
      .sys_clk_i(clk), .sys_rst_i(rst), .j1_io_rd(j1_io_rd), .j1_io_wr(j1_io_wr),
      .j1_io_addr(j1_io_addr), .j1_io_dout(j1_io_dout), .j1_io_din(j1_io_din),
      .j1_io_stall(j1_io_stall), .per_cs(per_cs), .per_rd(per_rd), .per_wr(per_wr),
      .per_addr(per_addr), .per_din(per_din), .per_dout(per_dout), .per_ack(per_ack),
      .err_irq(err_irq)
   );
   task automatic model_reset();
      m_cnt = '0;
      m_last = '0;
      m_cause = '0;
      m_irq = 1'b0;
      m_rdata = DEF;
   endtask
   task automatic log_err(input logic [15:0] a, input logic [2:0] bits);
      m_cnt = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
      m_last = a;
      m_cause = m_cause | bits;
      m_irq = 1'b1;
   endtask
   task automatic predict(input logic rd, input logic wr, input logic [15:0] a, input int ack_after,
                          input logic [N*16-1:0] pd, output int e_stall, output logic [15:0] e_din,
                          output logic [N-1:0] e_cs);
      int idx;
      logic [7:0] pg, off;
      pg = a[15:8];
      off = a[7:0];
      idx = -1;
      for (int i = 0; i < N; i++) if (idx < 0 && PAGES[i] == pg) idx = i;
      e_stall = 0;
      e_din = DEF;
      e_cs = '0;
      if ((rd && wr) || (idx < 0 && pg != STAT)) log_err(a, {rd && wr, idx < 0 && pg != STAT, 1'b0});
      else if (idx >= 0) begin
         e_cs = N'(1) << idx;
         if (ack_after < TIMEOUT) begin
            e_stall = ack_after + 2;
            if (rd) m_rdata = pd[idx*16 +: 16];
         end else begin
            e_stall = TIMEOUT + 1;
            m_rdata = DEF;
            log_err(a, 3'b001);
         end
         e_din = m_rdata;
      end else if (rd) e_din = off == 0 ? m_cnt : off == 1 ? m_last : off == 2 ? {13'b0, m_cause} : DEF;
      else if (off == 0) begin
         m_cnt = '0;
         m_cause = '0;
         m_irq = 1'b0;
      end
   endtask
   task automatic drive(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d,
                        input int ack_after, input logic [N*16-1:0] pd, output obs_t o);
      o = '0;
      j1_io_rd = rd;
      j1_io_wr = wr;
      j1_io_addr = a;
      j1_io_dout = d;
      per_dout = pd;
      for (int c = 0; c < 64; c++) begin
         per_ack = (N'($urandom) & ~per_cs) | ((c >= 1 && c - 1 == ack_after) ? per_cs : '0);
         #4;
         if (!j1_io_stall) begin
            o.din = j1_io_din;
            o.cs_done = per_cs;
            break;
         end
         o.stall = o.stall + 1;
         o.wr_cyc = o.wr_cyc + (per_wr ? 1 : 0);
         if (c == 1) begin
            o.cs = per_cs;
            o.rd = per_rd;
            o.wr = per_wr;
            o.addr = per_addr;
            o.dat = per_din;
         end
         @(posedge clk);
         #1;
      end
      @(posedge clk);
      #1;
      j1_io_rd = 1'b0;
      j1_io_wr = 1'b0;
      per_ack = '0;
   endtask
   task automatic op(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d,
                     input int ack_after, input logic [N*16-1:0] pd, output obs_t o, output int e_stall,
                     output logic [15:0] e_din, output logic [N-1:0] e_cs);
      predict(rd, wr, a, ack_after, pd, e_stall, e_din, e_cs);
      drive(rd, wr, a, d, ack_after, pd, o);
   endtask
   function automatic logic [N*16-1:0] rand_pd();
      logic [N*16-1:0] pd;
      for (int i = 0; i < N; i++) pd[i*16 +: 16] = 16'($urandom);
      return pd;
   endfunction
   task automatic test_reset();
      obs_t o;
      int es;
      logic [15:0] ed;
      logic [N-1:0] ec;
      model_reset();
      j1_io_rd = 1'b1;
      j1_io_addr = 16'h6803;
      #2;
      total++; if (j1_io_stall !== 1'b0) $display("FAIL reset_stall got %b exp 0", j1_io_stall); else passed++;
      total++; if (per_cs !== '0 || per_rd !== 1'b0 || per_wr !== 1'b0) $display("FAIL reset_strobes got cs=%b rd=%b wr=%b exp 0", per_cs, per_rd, per_wr); else passed++;
      total++; if (per_addr !== 8'h00 || per_din !== 16'h0000) $display("FAIL reset_addr_data got %h/%h exp 0", per_addr, per_din); else passed++;
      total++; if (err_irq !== 1'b0) $display("FAIL reset_irq got %b exp 0", err_irq); else passed++;
      total++; if (j1_io_din !== DEF) $display("FAIL reset_din got %h exp %h", j1_io_din, DEF); else passed++;
      @(posedge clk);
      #1;
      j1_io_rd = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      #1;
      for (int off = 0; off < 3; off++) begin
         op(1'b1, 1'b0, {STAT, 8'(off)}, 16'h0, 0, '0, o, es, ed, ec);
         total++; if (o.din !== ed) $display("FAIL reset_status%0d got %h exp %h", off, o.din, ed); else passed++;
      end
   endtask
   task automatic test_write_wait();
      obs_t o;
      int es;
      logic [15:0] ed;
      logic [N-1:0] ec;
      op(1'b0, 1'b1, 16'h6912, 16'hBEEF, 4, rand_pd(), o, es, ed, ec);
      total++; if (o.stall !== es) $display("FAIL wr_stall got %0d exp %0d", o.stall, es); else passed++;
      total++; if (o.cs !== 5'b00100) $display("FAIL wr_cs got %b exp 00100", o.cs); else passed++;
      total++; if (o.wr_cyc !== 5 || o.wr !== 1'b1 || o.rd !== 1'b0) $display("FAIL wr_strobe got %0d cycles rd=%b exp 5 cycles rd=0", o.wr_cyc, o.rd); else passed++;
      total++; if (o.dat !== 16'hBEEF || o.addr !== 8'h12) $display("FAIL wr_data got %h@%h exp BEEF@12", o.dat, o.addr); else passed++;
      total++; if (o.din !== ed) $display("FAIL wr_done_din got %h exp %h", o.din, ed); else passed++;
      total++; if (o.cs_done !== '0) $display("FAIL wr_done_cs got %b exp 0", o.cs_done); else passed++;
   endtask
   task automatic test_read_ack();
      obs_t o;
      int es;
      logic [15:0] ed;
      logic [N-1:0] ec;
      logic [N*16-1:0] pd;
      pd = rand_pd();
      pd[31:16] = 16'h1234;
      op(1'b1, 1'b0, 16'h6803, 16'h0, 0, pd, o, es, ed, ec);
      total++; if (o.stall !== 2) $display("FAIL rd_stall got %0d exp 2", o.stall); else passed++;
      total++; if (o.din !== 16'h1234) $display("FAIL rd_din got %h exp 1234", o.din); else passed++;
      total++; if (o.cs !== 5'b00010 || o.rd !== 1'b1 || o.addr !== 8'h03) $display("FAIL rd_cs got %b rd=%b addr=%h exp 00010 1 03", o.cs, o.rd, o.addr); else passed++;
   endtask
   task automatic test_timeout();
      obs_t o;
      int es;
      logic [15:0] ed;
      logic [N-1:0] ec;
      logic [N*16-1:0] pd;
      pd = rand_pd();
      op(1'b1, 1'b0, 16'h6A00 - 16'h0300, 16'h0, TIMEOUT - 1, pd, o, es, ed, ec);
      total++; if (o.stall !== es || o.din !== pd[15:0]) $display("FAIL last_cycle_ack got %0d/%h exp %0d/%h", o.stall, o.din, es, pd[15:0]); else passed++;
      total++; if (err_irq !== 1'b0) $display("FAIL last_cycle_irq got %b exp 0", err_irq); else passed++;
      op(1'b1, 1'b0, 16'h6744, 16'h0, 1000, rand_pd(), o, es, ed, ec);
      total++; if (o.stall !== TIMEOUT + 1) $display("FAIL to_stall got %0d exp %0d", o.stall, TIMEOUT + 1); else passed++;
      total++; if (o.din !== DEF) $display("FAIL to_din got %h exp %h", o.din, DEF); else passed++;
      total++; if (err_irq !== 1'b1) $display("FAIL to_irq got %b exp 1", err_irq); else passed++;
      op(1'b1, 1'b0, 16'h7F00, 16'h0, 0, '0, o, es, ed, ec);
      total++; if (o.din !== 16'h0001) $display("FAIL to_count got %h exp 0001", o.din); else passed++;
      op(1'b1, 1'b0, 16'h7F01, 16'h0, 0, '0, o, es, ed, ec);
      total++; if (o.din !== 16'h6744) $display("FAIL to_addr got %h exp 6744", o.din); else passed++;
      op(1'b1, 1'b0, 16'h7F02, 16'h0, 0, '0, o, es, ed, ec);
      total++; if (o.din !== 16'h0001) $display("FAIL to_cause got %h exp 0001", o.din); else passed++;
   endtask
   task automatic test_unmapped_clear();
      obs_t o;
      int es;
      logic [15:0] ed;
      logic [N-1:0] ec;
      op(1'b1, 1'b0, 16'h55AB, 16'h0, 0, rand_pd(), o, es, ed, ec);
      total++; if (o.stall !== 0 || o.din !== DEF || o.cs_done !== '0) $display("FAIL unm got stall=%0d din=%h cs=%b exp 0 %h 0", o.stall, o.din, o.cs_done, DEF); else passed++;
      op(1'b1, 1'b0, 16'h7F01, 16'h0, 0, '0, o, es, ed, ec);
      total++; if (o.din !== 16'h55AB) $display("FAIL unm_addr got %h exp 55AB", o.din); else passed++;
      op(1'b1, 1'b0, 16'h7F02, 16'h0, 0, '0, o, es, ed, ec);
      total++; if (o.din !== ed || o.din[1] !== 1'b1) $display("FAIL unm_cause got %h exp %h", o.din, ed); else passed++;
      op(1'b0, 1'b1, 16'h7F00, 16'h0, 0, '0, o, es, ed, ec);
      total++; if (err_irq !== 1'b0) $display("FAIL clr_irq got %b exp 0", err_irq); else passed++;
      op(1'b1, 1'b0, 16'h7F00, 16'h0, 0, '0, o, es, ed, ec);
      total++; if (o.din !== 16'h0000) $display("FAIL clr_count got %h exp 0000", o.din); else passed++;
      op(1'b1, 1'b0, 16'h7F02, 16'h0, 0, '0, o, es, ed, ec);
      total++; if (o.din !== 16'h0000) $display("FAIL clr_cause got %h exp 0000", o.din); else passed++;
   endtask
   task automatic test_random();
      for (int n = 0; n < 60; n++) begin
         obs_t o;
         int es, k, aa;
         logic [15:0] ed, a;
         logic [N-1:0] ec;
         logic rd, wr;
         k = $urandom_range(0, 9);
         rd = 1'($urandom_range(0, 1));
         wr = !rd;
         aa = $urandom_range(0, 17);
         a = {PAGES[$urandom_range(0, N - 1)], 8'($urandom)};
         if (k == 6) a[15:8] = 8'($urandom_range(0, 8'h66));
         if (k == 7) begin rd = 1'b1; wr = 1'b0; a = {STAT, 8'($urandom_range(0, 3))}; end
         if (k == 8) begin rd = 1'b0; wr = 1'b1; a = {STAT, 8'($urandom_range(0, 1))}; end
         if (k == 9) begin rd = 1'b1; wr = 1'b1; end
         op(rd, wr, a, 16'($urandom), aa, rand_pd(), o, es, ed, ec);
         total++; if (o.stall !== es) $display("FAIL rnd%0d_stall got %0d exp %0d", n, o.stall, es); else passed++;
         total++; if (o.din !== ed) $display("FAIL rnd%0d_din got %h exp %h", n, o.din, ed); else passed++;
         total++; if (o.cs !== ec || o.cs_done !== '0) $display("FAIL rnd%0d_cs got %b/%b exp %b/0", n, o.cs, o.cs_done, ec); else passed++;
         total++; if (es > 0 && (o.rd !== rd || o.wr !== wr || o.addr !== a[7:0])) $display("FAIL rnd%0d_strobe got %b%b@%h exp %b%b@%h", n, o.rd, o.wr, o.addr, rd, wr, a[7:0]); else passed++;
         total++; if (err_irq !== m_irq) $display("FAIL rnd%0d_irq got %b exp %b", n, err_irq, m_irq); else passed++;
      end
   endtask
   task automatic test_conflict_sat();
      obs_t o;
      int es;
      logic [15:0] ed;
      logic [N-1:0] ec;
      logic bad;
      bad = 1'b0;
      j1_io_rd = 1'b1;
      j1_io_wr = 1'b1;
      j1_io_addr = 16'h6801;
      per_ack = '0;
      for (int n = 0; n < 65537; n++) begin
         #4;
         if (j1_io_stall !== 1'b0 || per_cs !== '0) bad = 1'b1;
         log_err(16'h6801, 3'b100);
         @(posedge clk);
         #1;
      end
      j1_io_rd = 1'b0;
      j1_io_wr = 1'b0;
      total++; if (bad) $display("FAIL conflict_no_stall got stall/cs activity exp none"); else passed++;
      op(1'b1, 1'b0, 16'h7F00, 16'h0, 0, '0, o, es, ed, ec);
      total++; if (o.din !== 16'hFFFF) $display("FAIL sat_count got %h exp FFFF", o.din); else passed++;
      op(1'b1, 1'b0, 16'h7F02, 16'h0, 0, '0, o, es, ed, ec);
      total++; if (o.din !== ed || o.din[2] !== 1'b1) $display("FAIL conflict_cause got %h exp %h", o.din, ed); else passed++;
   endtask
   task automatic test_reset_mid_access();
      obs_t o;
      int es;
      logic [15:0] ed;
      logic [N-1:0] ec;
      j1_io_rd = 1'b1;
      j1_io_wr = 1'b0;
      j1_io_addr = 16'h7004;
      per_ack = '0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      #1;
      total++; if (j1_io_stall !== 1'b1 || per_cs !== 5'b01000) $display("FAIL mid_access got stall=%b cs=%b exp 1 01000", j1_io_stall, per_cs); else passed++;
      rst = 1'b1;
      #1;
      total++; if (j1_io_stall !== 1'b0 || per_cs !== '0 || per_rd !== 1'b0) $display("FAIL mid_reset got stall=%b cs=%b rd=%b exp 0", j1_io_stall, per_cs, per_rd); else passed++;
      @(posedge clk);
      #1;
      j1_io_rd = 1'b0;
      rst = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      op(1'b1, 1'b0, 16'h7F00, 16'h0, 0, '0, o, es, ed, ec);
      total++; if (o.din !== ed) $display("FAIL mid_count got %h exp %h", o.din, ed); else passed++;
      op(1'b1, 1'b0, 16'h6800, 16'h0, 0, rand_pd(), o, es, ed, ec);
      total++; if (o.stall !== 2 || o.din !== ed) $display("FAIL post_reset got %0d/%h exp 2/%h", o.stall, o.din, ed); else passed++;
   endtask
   initial begin
      @(posedge clk);
      #1;
      test_reset();
      test_write_wait();
      test_read_ack();
      test_timeout();
      test_unmapped_clear();
      test_random();
      test_conflict_sat();
      test_reset_mid_access();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
